// File: rtl/ram_16x4_sync_pkg.sv
// Shared constants and types for the 16x4 synchronous register-file RAM.
package ram_16x4_sync_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 4;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/ram_16x4_sync.sv
// Single-port flop-based RAM. Reads are registered and read-first on a
// same-cycle write. Reset clears both the storage and the output.
module ram_16x4_sync
  import ram_16x4_sync_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Data,
  input  logic              RD,
  input  logic              WR,
  input  logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Output
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DATA_W-1:0]            out_q, out_d;

  // Read samples mem_q, so a simultaneous write is seen only on a later read.
  always_comb begin
    mem_d = mem_q;
    out_d = out_q;
    if (WR) mem_d[Address] = Data;
    if (RD) out_d = mem_q[Address];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      out_q <= '0;
    end else begin
      mem_q <= mem_d;
      out_q <= out_d;
    end
  end

  assign Output = out_q;

endmodule

// File: tb/tb_ram_16x4_sync.sv
// Directed-vector bench for ram_16x4_sync with hand-computed expected values.
module tb_ram_16x4_sync;

  logic       clk;
  logic       rst;
  logic [3:0] Data;
  logic       RD;
  logic       WR;
  logic [3:0] Address;
  logic [3:0] Output;

  int n_vec;
  int n_err;

  ram_16x4_sync dut (
    .clk    (clk),
    .rst    (rst),
    .Data   (Data),
    .RD     (RD),
    .WR     (WR),
    .Address(Address),
    .Output (Output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one access, clock it in, and settle 1 time unit past the edge.
  task automatic op(input logic rd, input logic wr, input logic [3:0] a, input logic [3:0] d);
    RD = rd; WR = wr; Address = a; Data = d;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_mem [16];

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; RD = 1'b0; WR = 1'b0; Address = '0; Data = '0;
    #1;
    chk("reset_out", Output, 4'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // fill: mem[A] = A
    for (int a = 0; a < 16; a++) op(1'b0, 1'b1, 4'(a), 4'(a));
    for (int a = 0; a < 16; a++) begin
      op(1'b1, 1'b0, 4'(a), 4'h0);
      chk($sformatf("fill_rd%0d", a), Output, 4'(a));
    end

    // hold: RD low keeps last read value while Address moves
    op(1'b1, 1'b0, 4'd5, 4'h0);
    chk("hold_rd5", Output, 4'h5);
    for (int i = 0; i < 3; i++) begin
      op(1'b0, 1'b0, 4'd9, 4'h0);
      chk($sformatf("hold_c%0d", i), Output, 4'h5);
    end

    // read-first collision
    op(1'b1, 1'b1, 4'd3, 4'hA);
    chk("coll_old", Output, 4'h3);
    op(1'b1, 1'b0, 4'd3, 4'h0);
    chk("coll_new", Output, 4'hA);

    // overwrite / isolation
    op(1'b0, 1'b1, 4'd0, 4'hF);
    op(1'b0, 1'b1, 4'd15, 4'h0);
    op(1'b1, 1'b0, 4'd0, 4'h0);
    chk("ovw_a0", Output, 4'hF);
    op(1'b1, 1'b0, 4'd15, 4'h0);
    chk("ovw_a15", Output, 4'h0);
    op(1'b1, 1'b0, 4'd1, 4'h0);
    chk("ovw_a1", Output, 4'h1);

    // idle: no strobes, inputs toggling
    for (int i = 0; i < 5; i++) begin
      op(1'b0, 1'b0, 4'(i * 3 + 2), 4'(15 - i));
      chk($sformatf("idle_c%0d", i), Output, 4'h1);
    end

    for (int a = 0; a < 16; a++) exp_mem[a] = 4'(a);
    exp_mem[0] = 4'hF; exp_mem[3] = 4'hA; exp_mem[15] = 4'h0;
    for (int a = 0; a < 16; a++) begin
      op(1'b1, 1'b0, 4'(a), 4'h0);
      chk($sformatf("idle_rd%0d", a), Output, exp_mem[a]);
    end

    // leave a nonzero value on Output, then reset asynchronously mid-cycle
    op(1'b1, 1'b0, 4'd3, 4'h0);
    chk("pre_rst", Output, 4'hA);
    RD = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", Output, 4'h0);
    RD = 1'b1; WR = 1'b1; Address = 4'd4; Data = 4'h7;
    @(posedge clk); #1;
    chk("rst_held", Output, 4'h0);
    RD = 1'b0; WR = 1'b0;
    rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      op(1'b1, 1'b0, 4'(a), 4'h0);
      chk($sformatf("post_rst_rd%0d", a), Output, 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_16x4_sync.md
Name: ram_16x4_sync

Overview:
- Single-port 16-word x 4-bit register-file RAM with separate write-enable and read-enable strobes.
- Data written on WR, read back on Output on RD; fully synchronous to one clock, all storage flop-based.
- Used as a small scratch/lookup store; memory contents and output are cleared by reset.

Parameters:
- DATA_W, 4, width of each word and of Data/Output.
- ADDR_W, 4, address width.
- DEPTH, 2**ADDR_W (16), number of words; derived, not independently overridable.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- Data  input  DATA_W  write data.
- RD  input  1  read enable, active high.
- WR  input  1  write enable, active high.
- Address  input  ADDR_W  word address, shared by read and write.
- Output  output  DATA_W  registered read data.

Behaviour:
- Reset: rst high asynchronously forces all DEPTH words to 0 and Output to 0. This holds while rst is asserted; no access is performed in that state. First access is on the first rising clk edge after deassertion.
- Write: on rising clk with WR=1, mem[Address] <= Data. Latency 1 cycle; a read of the same address one cycle later returns the new value.
- Read: on rising clk with RD=1, Output <= mem[Address]. Data is visible on Output after that edge (1-cycle latency).
- Hold: RD=0 means Output holds its last value. It is never driven to 0 or X except by reset.
- Idle: RD=0 and WR=0 means no state changes.
- Simultaneous RD=1 and WR=1:
  - The write is performed.
  - Output gets the contents before the write (read-first semantics).
  - The new value is readable on the next RD cycle.
- Address is always in range (full 4-bit decode, 16 words); no wrap or out-of-range case exists.
- Address, Data, RD and WR are sampled only at rising clk; there are no combinational paths from inputs to Output.
- Unwritten words read as 0 after reset.

Decomposition:
- Shared package holds:
  - constants DATA_W_DEF=4 and ADDR_W_DEF=4;
  - typedefs word_t (logic [DATA_W-1:0]) and addr_t (logic [ADDR_W-1:0]).
- No sub-module. Storage array, write decode and output register live in one module.

Test Plan:
- Reset: assert rst mid-simulation after words are written -> Output=0 immediately (asynchronous). After release, RD=1 at any address returns 0.
- Fill/readback:
  - Write pass: for A=0..15, WR=1 RD=0 Data=A Address=A, one cycle each.
  - Read pass: RD=1 WR=0 for A=0..15 -> Output=A one cycle after each read edge.
- Hold: read addr 5 (Output=5), then RD=0 with Address=9 for 3 cycles -> Output stays 5.
- Read-first collision:
  - mem[3]=3; then RD=1 WR=1 Address=3 Data=4'hA -> Output=3.
  - Next cycle RD=1 WR=0 -> Output=4'hA.
- Overwrite/isolation: write 4'hF to addr 0 and 4'h0 to addr 15 -> read addr 0 =4'hF, addr 15 =0, addr 1 unchanged (=1).
- Idle: RD=0 WR=0 with changing Data/Address for 5 cycles -> no memory or Output change (verify by full readback).
